// File: rtl/avalon_input_pio_dbnc.sv
// Avalon-MM input PIO: sync, optional debounce (PIO_DEBOUNCE_EN), edge capture, irq.
// EDGE_CAP is write-1-to-clear; a new edge in the clearing cycle keeps the bit set.
module avalon_input_pio_dbnc #(
  parameter int W           = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DBNC_CYCLES = 50000,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          chipselect,
  input  logic [2:0]    address,
  input  logic          write_n,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  input  logic [W-1:0]  in_port,
  output logic          irq
);

  if (W < 1 || W > 32) begin : g_bad_w
    $error("W must be 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (CNT_W < 1 || CNT_W > 30 || (2 ** CNT_W) <= DBNC_CYCLES || DBNC_CYCLES < 1) begin : g_bad_cnt
    $error("need 2**CNT_W > DBNC_CYCLES >= 1");
  end

  logic [W-1:0]  sync_q [SYNC_STAGES];
  logic [W-1:0]  sync_d [SYNC_STAGES];
  logic [W-1:0]  s;
  logic [W-1:0]  filt_q, filt_d;
  logic [W-1:0]  prev_q;
  logic [W-1:0]  rise_en_q, rise_en_d;
  logic [W-1:0]  mask_q, mask_d;
  logic [W-1:0]  cap_q, cap_d;
  logic [W-1:0]  fall_en_q, fall_en_d;
  logic [31:0]   readdata_q, readdata_d;
  logic [W-1:0]  rise, fall, ev, w1c, wd;
  logic          we;
  logic          unused_wd;

  assign unused_wd = ^writedata;
  assign s         = sync_q[SYNC_STAGES-1];
  assign wd        = writedata[W-1:0];
  assign we        = chipselect && !write_n;

  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '{default: '0};
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_q [W];
  logic [CNT_W-1:0] cnt_d [W];

  // Counter only runs while s disagrees with filt, so it cannot pass DBNC_CYCLES-1
  always_comb begin
    filt_d = filt_q;
    for (int k = 0; k < W; k++) begin
      cnt_d[k] = '0;
      if (s[k] != filt_q[k]) begin
        if (cnt_q[k] == CNT_W'(DBNC_CYCLES - 1)) begin
          filt_d[k] = s[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    filt_d = s;
  end
`endif

  assign rise = filt_q & ~prev_q;
  assign fall = ~filt_q & prev_q;
  assign ev   = (rise & rise_en_q) | (fall & fall_en_q);
  assign w1c  = (we && address == 3'd3) ? wd : '0;

  always_comb begin
    rise_en_d = rise_en_q;
    mask_d    = mask_q;
    fall_en_d = fall_en_q;
    if (we) begin
      case (address)
        3'd1:    rise_en_d = wd;
        3'd2:    mask_d    = wd;
        3'd4:    fall_en_d = wd;
        default: ;
      endcase
    end
    cap_d = ev | (cap_q & ~w1c);
    case (address)
      3'd0:    readdata_d = 32'(filt_q);
      3'd1:    readdata_d = 32'(rise_en_q);
      3'd2:    readdata_d = 32'(mask_q);
      3'd3:    readdata_d = 32'(cap_q);
      3'd4:    readdata_d = 32'(fall_en_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q     <= '0;
      prev_q     <= '0;
      rise_en_q  <= '1;
      mask_q     <= '0;
      cap_q      <= '0;
      fall_en_q  <= '0;
      readdata_q <= '0;
    end else begin
      filt_q     <= filt_d;
      prev_q     <= filt_q;
      rise_en_q  <= rise_en_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      fall_en_q  <= fall_en_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_avalon_input_pio_dbnc.sv
// Scoreboard bench for avalon_input_pio_dbnc: directed reads/irq probes,
// expectations queued at issue time and checked by a separate monitor.
module tb_avalon_input_pio_dbnc;

  localparam int SS = 2;
  localparam int DB = 8;
`ifdef PIO_DEBOUNCE_EN
  localparam int LAT = SS + DB;
`else
  localparam int LAT = SS + 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  in_port;
  logic        irq;

  typedef struct {
    bit          is_irq;
    logic [31:0] exp;
    string       nm;
  } sb_t;

  sb_t sb[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  bit  req    = 1'b0;

  avalon_input_pio_dbnc #(
    .W(2), .SYNC_STAGES(SS), .DBNC_CYCLES(DB), .CNT_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect),
    .address(address), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Monitor: one queued expectation is consumed on each edge that carries a request
  initial begin
    sb_t         e;
    logic [31:0] act;
    forever begin
      @(posedge clk);
      if (req) begin
        #1;
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL sb_empty: got response with no expectation");
        end else begin
          e   = sb.pop_front();
          act = e.is_irq ? {31'b0, irq} : readdata;
          if (act !== e.exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", e.nm, act, e.exp);
          else
            n_pass++;
        end
      end
    end
  end

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = '0;
    req        = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] x, input string nm);
    sb_t e;
    e.is_irq   = 1'b0;
    e.exp      = x;
    e.nm       = nm;
    sb.push_back(e);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    req        = 1'b1;
    @(negedge clk);
    idle();
  endtask

  task automatic chk_irq(input logic x, input string nm);
    sb_t e;
    e.is_irq = 1'b1;
    e.exp    = {31'b0, x};
    e.nm     = nm;
    sb.push_back(e);
    req      = 1'b1;
    @(negedge clk);
    idle();
  endtask

  task automatic settle();
    repeat (LAT + 3) @(negedge clk);
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    in_port = 2'b11;
    repeat (2) @(negedge clk);

    // T1 reset
    rd(3'd1, 32'h0, "rst_readdata");
    chk_irq(1'b0, "rst_irq");
    rd(3'd3, 32'h0, "rst_readdata2");
    reset_n = 1'b1;
    rd(3'd1, 32'h3, "rise_en_rst");
    rd(3'd2, 32'h0, "mask_rst");
    rd(3'd4, 32'h0, "fall_en_rst");
    repeat (LAT + 2) @(negedge clk);
    rd(3'd3, 32'h3, "cap_after_rst");
    rd(3'd0, 32'h3, "data_high");
    chk_irq(1'b0, "irq_masked_rst");
    in_port = 2'b00;
    settle();
    rd(3'd3, 32'h3, "fall_disabled");

    // T2 rising edge + irq timing
    wr(3'd2, 32'h1);
    wr(3'd3, 32'h3);
    chk_irq(1'b0, "irq_cleared");
    rd(3'd3, 32'h0, "cap_cleared");
    in_port = 2'b01;
    for (int i = 0; i < LAT; i++) chk_irq(1'b0, "irq_early");
    chk_irq(1'b1, "irq_on_time");
    rd(3'd3, 32'h1, "cap_rise0");
    in_port = 2'b00;
    settle();
    rd(3'd3, 32'h1, "cap_hold");
    wr(3'd3, 32'h1);
    chk_irq(1'b0, "irq_w1c");
    rd(3'd3, 32'h0, "cap_w1c");

    // T3 falling only
    wr(3'd1, 32'h0);
    wr(3'd4, 32'h2);
    in_port = 2'b10;
    settle();
    rd(3'd3, 32'h0, "no_rise_cap");
    rd(3'd0, 32'h2, "data_10");
    in_port = 2'b00;
    settle();
    rd(3'd3, 32'h2, "fall_cap");
    rd(3'd0, 32'h0, "data_00");
    chk_irq(1'b0, "irq_unmasked_bit");
    wr(3'd2, 32'h3);
    chk_irq(1'b1, "irq_late_mask");
    wr(3'd3, 32'h2);
    chk_irq(1'b0, "irq_fall_clr");

    // T4 clear/edge collision
    wr(3'd1, 32'h1);
    in_port = 2'b01;
    settle();
    chk_irq(1'b1, "irq_pre_coll");
    rd(3'd3, 32'h1, "cap_pre_coll");
    in_port = 2'b00;
    settle();
    in_port = 2'b01;
    repeat (LAT) @(negedge clk);
    wr(3'd3, 32'h1);
    chk_irq(1'b1, "irq_coll");
    rd(3'd3, 32'h1, "cap_coll");
    wr(3'd3, 32'h1);
    rd(3'd3, 32'h0, "cap_after_coll");
    chk_irq(1'b0, "irq_after_coll");
    in_port = 2'b00;
    settle();

    // T6 unused register space
    wr(3'd2, 32'hFFFF_FFFF);
    rd(3'd2, 32'h3, "mask_width");
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, 32'h0, "addr6");
    rd(3'd7, 32'h0, "addr7");
    rd(3'd5, 32'h0, "addr5");
    wr(3'd1, 32'hFFFF_FFFC);
    rd(3'd1, 32'h0, "rise_en_width");

`ifdef PIO_DEBOUNCE_EN
    // T5 debounce
    wr(3'd1, 32'h1);
    wr(3'd3, 32'h3);
    in_port = 2'b01;
    repeat (5) @(negedge clk);
    in_port = 2'b00;
    repeat (20) @(negedge clk);
    rd(3'd0, 32'h0, "glitch_data");
    rd(3'd3, 32'h0, "glitch_cap");
    in_port = 2'b01;
    repeat (SS + DB - 1) @(negedge clk);
    rd(3'd0, 32'h0, "dbnc_before");
    rd(3'd0, 32'h1, "dbnc_accept");
    in_port = 2'b00;
    rd(3'd3, 32'h1, "dbnc_cap");
    repeat (20) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
